// File: rtl/awb_gain_est_pkg.sv
// Shared definitions for the gray-world AWB gain estimator and the white-balance stage.
package awb_gain_est_pkg;

  // Colour codes carried on the tagged pixel stream
  localparam logic [1:0] COLOR_RED   = 2'd0;
  localparam logic [1:0] COLOR_GREEN = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd2;
  localparam logic [1:0] COLOR_NONE  = 2'd3;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIV,
    ST_UPDATE
  } state_t;

  // The five divisions issued back to back on the shared divider
  typedef enum logic [2:0] {
    DV_AVG_R,
    DV_AVG_G,
    DV_AVG_B,
    DV_GAIN_R,
    DV_GAIN_B
  } div_op_t;

  // Unity gain in the unsigned Q(8-frac_bits).frac_bits format
  function automatic logic [7:0] unity(input int frac_bits);
    return 8'(1 << frac_bits);
  endfunction

endpackage

// File: rtl/awb_gain_est_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, floor result.
// A division is one load cycle (i_start) followed by W iterations; o_done
// pulses in the cycle after the last iteration, which may also be the load
// cycle of the next division. Divide by zero yields an all-ones quotient.
module seq_divider #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_num,
  input  logic [W-1:0] i_den,
  output logic [W-1:0] o_quo,
  output logic         o_dz,
  output logic         o_done,
  output logic         o_last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_den;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_dz;

  logic [W:0]    w_rem_sh;
  logic [W+1:0]  w_diff;

  // Shift in the next dividend bit and trial-subtract the divisor
  always_comb begin
    w_rem_sh = {r_rem, r_quo[W-1]};
    w_diff   = {1'b0, w_rem_sh} - {2'b00, r_den};
  end

  // Load on start, otherwise iterate while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_num;
        r_den  <= i_den;
        r_cnt  <= CW'(W);
        r_busy <= 1'b1;
        r_dz   <= (i_den == '0);
      end else if (r_busy) begin
        if (!w_diff[W+1]) begin
          r_rem <= w_diff[W-1:0];
          r_quo <= {r_quo[W-2:0], 1'b1};
        end else begin
          r_rem <= w_rem_sh[W-1:0];
          r_quo <= {r_quo[W-2:0], 1'b0};
        end
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quo  = r_dz ? '1 : r_quo;
  assign o_dz   = r_dz;
  assign o_done = r_done;
  assign o_last = r_busy && (r_cnt == CW'(1));

endmodule

// File: rtl/awb_gain_est.sv
// Gray-world auto-white-balance gain estimator: accumulates per-channel sums
// over a frame, then derives K_R/K_B relative to green on a shared divider.
module awb_gain_est
  import awb_gain_est_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int FRAC_BITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start_i,
  input  logic       frame_end_i,
  input  logic       valid_i,
  input  logic [1:0] color_i,
  input  logic [7:0] value_i,
  output logic [7:0] K_R,
  output logic [7:0] K_G,
  output logic [7:0] K_B,
  output logic       gain_valid_o,
  output logic       busy_o
);

  localparam int         SUM_W = CNT_W + 8;
  localparam logic [7:0] UNITY = unity(FRAC_BITS);

  state_t           r_state, w_next_state;
  div_op_t          r_op, w_op_nxt;
  logic             r_kick;

  logic [SUM_W-1:0] r_sum [NUM_CH];
  logic [CNT_W-1:0] r_cnt [NUM_CH];
  logic [SUM_W-1:0] w_sum_nxt [NUM_CH];
  logic [CNT_W-1:0] w_cnt_nxt [NUM_CH];
  logic             w_clear;

  logic [7:0]       r_avg [NUM_CH];
  logic             r_bad [NUM_CH];
  logic [7:0]       r_gain_r;
  logic [7:0]       r_k_r, r_k_g, r_k_b;
  logic             r_gain_valid;
  logic             r_busy;

  logic             w_div_start;
  logic [SUM_W-1:0] w_div_num, w_div_den, w_div_quo;
  logic             w_div_dz, w_div_done, w_div_last;
  logic [7:0]       w_quo_sat;

  // Per-channel next sums/counts; a restart clears before the same-cycle pixel
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_clear = ((r_state == ST_IDLE) && frame_start_i) ||
              ((r_state == ST_ACCUM) && frame_start_i && !frame_end_i);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_sum_nxt[ch] = w_clear ? '0 : r_sum[ch];
      w_cnt_nxt[ch] = w_clear ? '0 : r_cnt[ch];
      if ((r_state == ST_ACCUM) && valid_i && (color_i == 2'(ch)) &&
          (w_cnt_nxt[ch] != '1)) begin
        w_sum_nxt[ch] = w_sum_nxt[ch] + SUM_W'(value_i);
        w_cnt_nxt[ch] = w_cnt_nxt[ch] + CNT_W'(1);
      end
    end
  end

  // Next state and divider sequencing
  always_comb begin
    w_next_state = r_state;
    w_div_start  = 1'b0;
    w_op_nxt     = r_op;
    case (r_state)
      ST_IDLE:   if (frame_start_i) w_next_state = ST_ACCUM;
      ST_ACCUM:  if (frame_end_i)   w_next_state = ST_DIV;
      ST_DIV: begin
        if (r_kick || w_div_done) begin
          w_div_start = 1'b1;
          w_op_nxt    = r_kick ? DV_AVG_R : div_op_t'(r_op + 3'd1);
        end
        if (w_div_last && (r_op == DV_GAIN_B)) w_next_state = ST_UPDATE;
      end
      ST_UPDATE: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Operand selection for the division about to be loaded
  always_comb begin
    w_div_num = '0;
    w_div_den = '0;
    case (w_op_nxt)
      DV_AVG_R: begin
        w_div_num = r_sum[COLOR_RED];
        w_div_den = SUM_W'(r_cnt[COLOR_RED]);
      end
      DV_AVG_G: begin
        w_div_num = r_sum[COLOR_GREEN];
        w_div_den = SUM_W'(r_cnt[COLOR_GREEN]);
      end
      DV_AVG_B: begin
        w_div_num = r_sum[COLOR_BLUE];
        w_div_den = SUM_W'(r_cnt[COLOR_BLUE]);
      end
      DV_GAIN_R: begin
        w_div_num = SUM_W'({r_avg[COLOR_GREEN], {FRAC_BITS{1'b0}}});
        w_div_den = SUM_W'(r_avg[COLOR_RED]);
      end
      DV_GAIN_B: begin
        w_div_num = SUM_W'({r_avg[COLOR_GREEN], {FRAC_BITS{1'b0}}});
        w_div_den = SUM_W'(r_avg[COLOR_BLUE]);
      end
      default: begin
        w_div_num = '0;
        w_div_den = '0;
      end
    endcase
  end

  assign w_quo_sat = (|w_div_quo[SUM_W-1:8]) ? 8'hFF : w_div_quo[7:0];

  seq_divider #(.W(SUM_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_div_start),
    .i_num   (w_div_num),
    .i_den   (w_div_den),
    .o_quo   (w_div_quo),
    .o_dz    (w_div_dz),
    .o_done  (w_div_done),
    .o_last  (w_div_last)
  );

  // FSM state, divider bookkeeping and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= DV_AVG_R;
      r_kick  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      r_op    <= w_op_nxt;
      r_kick  <= (r_state == ST_ACCUM) && frame_end_i;
      r_busy  <= (w_next_state == ST_DIV) || (w_next_state == ST_UPDATE) ||
                 (r_state == ST_UPDATE);
    end
  end

  // Frame accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these small arrays are flops, not RAM, so they are reset like any other register.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_sum[ch] <= '0;
        r_cnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_sum[ch] <= w_sum_nxt[ch];
        r_cnt[ch] <= w_cnt_nxt[ch];
      end
    end
  end

  // Capture division results and publish gains in UPDATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_avg[ch] <= '0;
        r_bad[ch] <= 1'b1;
      end
      r_gain_r     <= '0;
      r_k_r        <= UNITY;
      r_k_g        <= UNITY;
      r_k_b        <= UNITY;
      r_gain_valid <= 1'b0;
    end else begin
      r_gain_valid <= 1'b0;
      if ((r_state == ST_DIV) && w_div_done) begin
        case (r_op)
          DV_AVG_R: begin
            r_avg[COLOR_RED] <= w_div_quo[7:0];
            r_bad[COLOR_RED] <= w_div_dz || (w_div_quo == '0);
          end
          DV_AVG_G: begin
            r_avg[COLOR_GREEN] <= w_div_quo[7:0];
            r_bad[COLOR_GREEN] <= w_div_dz || (w_div_quo == '0);
          end
          DV_AVG_B: begin
            r_avg[COLOR_BLUE] <= w_div_quo[7:0];
            r_bad[COLOR_BLUE] <= w_div_dz || (w_div_quo == '0);
          end
          DV_GAIN_R: r_gain_r <= w_quo_sat;
          default:   r_gain_r <= r_gain_r;
        endcase
      end
      if (r_state == ST_UPDATE) begin
        r_k_g        <= UNITY;
        r_k_r        <= (r_bad[COLOR_RED]  || r_bad[COLOR_GREEN]) ? UNITY : r_gain_r;
        r_k_b        <= (r_bad[COLOR_BLUE] || r_bad[COLOR_GREEN]) ? UNITY : w_quo_sat;
        r_gain_valid <= 1'b1;
      end
    end
  end

  assign K_R          = r_k_r;
  assign K_G          = r_k_g;
  assign K_B          = r_k_b;
  assign gain_valid_o = r_gain_valid;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_awb_gain_est.sv
// Scoreboard bench for awb_gain_est: expected gains and update cycle are
// pushed at frame end and popped when gain_valid_o pulses.
module tb_awb_gain_est;
  import awb_gain_est_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start_i = 1'b0;
  logic       frame_end_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [1:0] color_i = 2'd0;
  logic [7:0] value_i = 8'd0;
  logic [7:0] K_R, K_G, K_B;
  logic       gain_valid_o, busy_o;

  localparam int LAT = 146;  // edges from frame_end sample to gain_valid visible, minus one

  typedef struct {
    logic [7:0] kr;
    logic [7:0] kg;
    logic [7:0] kb;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         m_sum[3];
  int         m_cnt[3];
  logic [7:0] m_k[3];
  logic [7:0] prev_k[3];

  awb_gain_est dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .frame_end_i   (frame_end_i),
    .valid_i       (valid_i),
    .color_i       (color_i),
    .value_i       (value_i),
    .K_R           (K_R),
    .K_G           (K_G),
    .K_B           (K_B),
    .gain_valid_o  (gain_valid_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_gain(input int c);
    int ac, ag, g;
    if (m_cnt[c] == 0 || m_cnt[1] == 0) return 8'd64;
    ac = m_sum[c] / m_cnt[c];
    ag = m_sum[1] / m_cnt[1];
    if (ac == 0 || ag == 0) return 8'd64;
    g = (ag * 64) / ac;
    return (g > 255) ? 8'd255 : 8'(g);
  endfunction

  // One input cycle; optionally tracked by the reference model
  task automatic send(input logic fs, input logic fe, input logic v,
                      input logic [1:0] col, input logic [7:0] val, input bit track);
    frame_start_i = fs;
    frame_end_i   = fe;
    valid_i       = v;
    color_i       = col;
    value_i       = val;
    @(posedge clk);
    #1;
    frame_start_i = 1'b0;
    frame_end_i   = 1'b0;
    valid_i       = 1'b0;
    color_i       = 2'd0;
    value_i       = 8'd0;
    if (track) begin
      if (fs && !fe) begin
        for (int c = 0; c < 3; c++) begin
          m_sum[c] = 0;
          m_cnt[c] = 0;
        end
      end
      if (v && col != 2'd3) begin
        m_sum[col] += int'(val);
        m_cnt[col] += 1;
      end
    end
  endtask

  task automatic pix(input logic [1:0] col, input logic [7:0] val);
    send(1'b0, 1'b0, 1'b1, col, val, 1'b1);
  endtask

  task automatic end_frame(input logic fs, input logic v, input logic [1:0] col,
                           input logic [7:0] val, output int e);
    exp_t x;
    send(fs, 1'b1, v, col, val, 1'b1);
    e = cyc;
    x.kr = model_gain(0);
    x.kg = 8'd64;
    x.kb = model_gain(2);
    x.at = e + LAT;
    sb.push_back(x);
    prev_k = m_k;
    m_k[0] = x.kr;
    m_k[1] = x.kg;
    m_k[2] = x.kb;
  endtask

  // Follow one computation: busy window, held gains mid-DIV, then drain
  task automatic wait_update(input int e);
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      if (cyc == e) check("busy_rise", busy_o, 1);
      if (cyc == e + 60) begin
        check("hold_kr", K_R, prev_k[0]);
        check("hold_kb", K_B, prev_k[2]);
      end
      if (cyc == e + LAT) check("busy_last", busy_o, 1);
      if (cyc == e + LAT + 1) begin
        check("busy_fall", busy_o, 0);
        break;
      end
    end
    check("sb_drained", sb.size(), 0);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n && gain_valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_gv", 1, 0);
      end else begin
        x = sb.pop_front();
        check("gv_cycle", cyc, x.at);
        check("k_r", K_R, x.kr);
        check("k_g", K_G, x.kg);
        check("k_b", K_B, x.kb);
      end
    end
  end

  initial begin
    int e;
    for (int c = 0; c < 3; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
      m_k[c]   = 8'd64;
      prev_k[c] = 8'd64;
    end

    // Reset state, idle with no frames
    #23 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_gv", gain_valid_o, 0);
      check("rst_busy", busy_o, 0);
    end
    check("rst_kr", K_R, 64);
    check("rst_kg", K_G, 64);
    check("rst_kb", K_B, 64);
    @(posedge clk);
    #1;

    // Basic frame, blue clamps at 255
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd100);
    pix(COLOR_GREEN, 8'd200);
    pix(COLOR_GREEN, 8'd200);
    end_frame(1'b0, 1'b1, COLOR_BLUE, 8'd50, e);
    wait_update(e);

    // Equal channels plus ignored colour-3 pixels
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd128);
    pix(COLOR_NONE, 8'd255);
    pix(COLOR_GREEN, 8'd128);
    pix(COLOR_RED, 8'd128);
    pix(COLOR_NONE, 8'd255);
    pix(COLOR_GREEN, 8'd128);
    pix(COLOR_BLUE, 8'd128);
    end_frame(1'b0, 1'b1, COLOR_BLUE, 8'd128, e);
    wait_update(e);

    // Empty frame
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    end_frame(1'b0, 1'b0, COLOR_RED, 8'd0, e);
    wait_update(e);

    // Zero red average falls back to unity
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd0);
    pix(COLOR_GREEN, 8'd60);
    end_frame(1'b0, 1'b1, COLOR_BLUE, 8'd30, e);
    wait_update(e);

    // Restart mid-frame keeps its own pixel; start+end together ends the frame
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd10);
    pix(COLOR_BLUE, 8'd200);
    send(1'b1, 1'b0, 1'b1, COLOR_RED, 8'd200, 1'b1);
    pix(COLOR_GREEN, 8'd100);
    end_frame(1'b1, 1'b1, COLOR_BLUE, 8'd40, e);
    wait_update(e);

    // Frame traffic while busy is ignored
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd100);
    pix(COLOR_GREEN, 8'd200);
    end_frame(1'b0, 1'b1, COLOR_BLUE, 8'd50, e);
    repeat (8) @(posedge clk);
    #1;
    send(1'b1, 1'b0, 1'b1, COLOR_RED, 8'd1, 1'b0);
    send(1'b0, 1'b0, 1'b1, COLOR_GREEN, 8'd255, 1'b0);
    send(1'b0, 1'b1, 1'b1, COLOR_BLUE, 8'd255, 1'b0);
    wait_update(e);
    repeat (20) @(negedge clk);
    check("idle_busy", busy_o, 0);

    // Asynchronous reset in the middle of DIV
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd50);
    pix(COLOR_GREEN, 8'd100);
    end_frame(1'b0, 1'b1, COLOR_BLUE, 8'd100, e);
    for (int i = 0; i < 200 && cyc < e + 80; i++) @(negedge clk);
    check("pre_rst_kr", K_R, 128);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_kr", K_R, 64);
    check("midrst_kg", K_G, 64);
    check("midrst_kb", K_B, 64);
    check("midrst_busy", busy_o, 0);
    check("midrst_gv", gain_valid_o, 0);
    sb.delete();
    for (int c = 0; c < 3; c++) m_k[c] = 8'd64;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_kr", K_R, 64);
    check("post_rst_busy", busy_o, 0);

    // Normal operation after reset
    @(posedge clk);
    #1;
    prev_k = m_k;
    send(1'b1, 1'b0, 1'b0, COLOR_RED, 8'd0, 1'b1);
    pix(COLOR_RED, 8'd64);
    pix(COLOR_GREEN, 8'd128);
    end_frame(1'b0, 1'b1, COLOR_BLUE, 8'd32, e);
    wait_update(e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
